// File: rtl/xmega_bus_pkg.sv
// Shared bus definitions for the mega_core data-side arbitration logic.
// Holds the default bus widths, the arbiter state encoding and requester indices.
package xmega_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int LOCK_CNT_W     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the shared data RAM port.
// Handshake: req (with we/lock/addr/wdata) is held until gnt; a cycle with req && gnt is one
// accepted access. For reads, rvalid pulses for one cycle on the following cycle with rdata.
interface dmem_arbiter_if #(
  parameter int AW = xmega_bus_pkg::DEF_ADDR_WIDTH,
  parameter int DW = xmega_bus_pkg::DEF_DATA_WIDTH
) ();

  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick; returns a one-hot grant (bit 0 = requester 0).
// On a tie the requester that did not win last time is chosen.
module rr_pick2
  import xmega_bus_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      gnt = (last == REQ1) ? 2'b01 : 2'b10;
    end else if (req0) begin
      gnt = 2'b01;
    end else if (req1) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data RAM port between the core data bus (m0) and a second master (m1).
// Round-robin when idle, optional bus locking bounded by MAX_LOCK while the other side waits.
module dmem_arbiter
  import xmega_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LOCK   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output arb_state_e            dbg_state,
  output logic [LOCK_CNT_W-1:0] dbg_lock_cnt
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_e            state_q, state_d;
  logic                  last_q, last_d;
  logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic                  rvalid0_q, rvalid1_q;
  logic [1:0]            pick;
  logic                  gnt0, gnt1;
  logic                  own_gnt, own_lock, other_req, expire;

  rr_pick2 u_pick (
    .req0 (m0.req),
    .req1 (m1.req),
    .last (last_q),
    .gnt  (pick)
  );

  // State register, lock counter, round-robin history and read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= REQ1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= gnt0 & ~m0.we;
      rvalid1_q  <= gnt1 & ~m1.we;
    end
  end

  // Next-state: a locked owner keeps the port until it drops lock or its quota expires.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    own_gnt    = 1'b0;
    own_lock   = 1'b0;
    other_req  = 1'b0;
    expire     = 1'b0;
    if (gnt0) begin
      last_d = REQ0;
    end else if (gnt1) begin
      last_d = REQ1;
    end
    unique case (state_q)
      IDLE: begin
        if (gnt0 && m0.lock) begin
          state_d = OWN0;
        end else if (gnt1 && m1.lock) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        own_gnt   = (state_q == OWN0) ? gnt0    : gnt1;
        own_lock  = (state_q == OWN0) ? m0.lock : m1.lock;
        other_req = (state_q == OWN0) ? m1.req  : m0.req;
        if (own_gnt && other_req && (lock_cnt_q < MAX_LOCK_C)) begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
        // The grant that brings the count to MAX_LOCK is the owner's last; last_d already
        // points at the owner, so the waiting side wins the next IDLE arbitration.
        expire = own_gnt && other_req && (lock_cnt_d >= MAX_LOCK_C);
        if (!own_lock || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      lock_cnt_d = '0;
    end
  end

  // Grant outputs: combinational, exclusive to the owner when locked, all low in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = pick[0];
        gnt1 = pick[1];
      end
      OWN0:    gnt0 = m0.req;
      OWN1:    gnt1 = m1.req;
      default: ;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    mem_re    = (gnt0 & ~m0.we) | (gnt1 & ~m1.we);
    mem_we    = (gnt0 & m0.we) | (gnt1 & m1.we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_addr  = m0.addr;
      mem_wdata = m0.wdata;
    end else if (gnt1) begin
      mem_addr  = m1.addr;
      mem_wdata = m1.wdata;
    end
  end

  assign m0.gnt       = gnt0;
  assign m1.gnt       = gnt1;
  assign m0.rvalid    = rvalid0_q;
  assign m1.rvalid    = rvalid1_q;
  assign m0.rdata     = mem_rdata;
  assign m1.rdata     = mem_rdata;
  assign dbg_state    = state_q;
  assign dbg_lock_cnt = lock_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed per-cycle vectors with hand-computed grants and read data.
// Expectations are queued by the driver and consumed by a negedge monitor.
module tb_dmem_arbiter;
  import xmega_bus_pkg::*;

  localparam int GW = 35;  // {cyc16, side, re, we, addr8, wdata8}
  localparam int RW = 25;  // {cyc16, side, rdata8}
  localparam int SW = 26;  // {cyc16, state2, lock_cnt8}

  logic       clk;
  logic       rst;
  logic       mem_re, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  arb_state_e dbg_state;
  logic [7:0] dbg_lock_cnt;

  int  cyc;
  bit  done;
  int  checks;
  int  errors;

  logic [GW-1:0] gnt_q[$];
  logic [RW-1:0] rd_q[$];
  logic [SW-1:0] st_q[$];
  logic [GW-1:0] g_obs, g_exp;
  logic [RW-1:0] r_obs, r_exp;
  logic [SW-1:0] s_obs, s_exp;

  bit         ram_v [256];
  logic [7:0] ram_d [256];

  dmem_arbiter_if #(.AW(8), .DW(8)) m0_if ();
  dmem_arbiter_if #(.AW(8), .DW(8)) m1_if ();

  dmem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_LOCK(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .m0           (m0_if),
    .m1           (m1_if),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_state    (dbg_state),
    .dbg_lock_cnt (dbg_lock_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // RAM model: unwritten locations read back as ~addr; data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      ram_v[mem_addr] <= 1'b1;
      ram_d[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= ram_v[mem_addr] ? ram_d[mem_addr] : ~mem_addr;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic vec(input logic r0, w0, l0, input logic [7:0] a0, d0,
                     input logic r1, w1, l1, input logic [7:0] a1, d1);
    m0_if.req = r0; m0_if.we = w0; m0_if.lock = l0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.req = r1; m1_if.we = w1; m1_if.lock = l1; m1_if.addr = a1; m1_if.wdata = d1;
    tick();
  endtask

  task automatic idle();
    vec(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic exp_gnt(input logic side, input logic we, input logic [7:0] a, input logic [7:0] d);
    gnt_q.push_back({16'(cyc), side, ~we, we, a, d});
  endtask

  task automatic exp_rd(input logic side, input logic [7:0] d);
    rd_q.push_back({16'(cyc + 1), side, d});
  endtask

  task automatic exp_st(input arb_state_e st, input logic [7:0] cnt);
    st_q.push_back({16'(cyc), st, cnt});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cyc  = 0;
    done = 1'b0;
    rst  = 1'b1;
    // Requests held during reset must not be granted.
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.lock = 1'b1; m0_if.addr = 8'h10; m0_if.wdata = 8'h00;
    m1_if.req = 1'b1; m1_if.we = 1'b0; m1_if.lock = 1'b0; m1_if.addr = 8'h20; m1_if.wdata = 8'h00;
    exp_st(IDLE, 8'd0);
    tick();
    exp_st(IDLE, 8'd0);
    tick();
    rst = 1'b0;

    // Both reading: alternate m0, m1, m0, m1 starting with m0.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        exp_gnt(1'b0, 1'b0, 8'h10, 8'h00); exp_rd(1'b0, 8'hEF);
      end else begin
        exp_gnt(1'b1, 1'b0, 8'h20, 8'h00); exp_rd(1'b1, 8'hDF);
      end
      vec(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h20, 8'h00);
    end
    idle();

    // m0 writes 0xA5 to 0x33, m1 reads it back.
    exp_gnt(1'b0, 1'b1, 8'h33, 8'hA5);
    vec(1, 1, 0, 8'h33, 8'hA5, 0, 0, 0, 8'h00, 8'h00);
    exp_gnt(1'b1, 1'b0, 8'h33, 8'h00); exp_rd(1'b1, 8'hA5);
    vec(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h33, 8'h00);
    idle();

    // m1 locked for 10 grants with m0 idle: no forced release, counter holds at 0.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) exp_st(OWN1, 8'd0);
      exp_gnt(1'b1, 1'b0, 8'h40, 8'h00); exp_rd(1'b1, 8'hBF);
      vec(0, 0, 0, 8'h00, 8'h00, 1, 0, (i < 9), 8'h40, 8'h00);
    end
    exp_st(IDLE, 8'd0);
    idle();

    // MAX_LOCK = 4: m1 enters the lock alone, then m0 waits through exactly 4 m1 grants.
    exp_gnt(1'b1, 1'b0, 8'h40, 8'h00); exp_rd(1'b1, 8'hBF);
    vec(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h40, 8'h00);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_st(OWN1, 8'd3);
      exp_gnt(1'b1, 1'b0, 8'h40, 8'h00); exp_rd(1'b1, 8'hBF);
      vec(1, 0, 0, 8'h10, 8'h00, 1, 0, 1, 8'h40, 8'h00);
    end
    exp_st(IDLE, 8'd0);
    exp_gnt(1'b0, 1'b0, 8'h10, 8'h00); exp_rd(1'b0, 8'hEF);
    vec(1, 0, 0, 8'h10, 8'h00, 1, 0, 1, 8'h40, 8'h00);
    exp_gnt(1'b1, 1'b0, 8'h40, 8'h00); exp_rd(1'b1, 8'hBF);
    vec(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h40, 8'h00);
    idle();

    // Locked m0 read granted, reset asserted before the read returns.
    m0_if.req = 1'b1; m0_if.we = 1'b0; m0_if.lock = 1'b1; m0_if.addr = 8'h10; m0_if.wdata = 8'h00;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.lock = 1'b0; m1_if.addr = 8'h00; m1_if.wdata = 8'h00;
    exp_gnt(1'b0, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    exp_st(IDLE, 8'd0);
    tick();
    rst = 1'b0;
    exp_gnt(1'b0, 1'b0, 8'h10, 8'h00); exp_rd(1'b0, 8'hEF);
    exp_st(IDLE, 8'd0);
    vec(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
    idle();

    // m0 alone alternating write/read; each read returns the value just written.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        exp_gnt(1'b0, 1'b1, 8'(8'h50 + i), 8'(8'h60 + i));
        vec(1, 1, 0, 8'(8'h50 + i), 8'(8'h60 + i), 0, 0, 0, 8'h00, 8'h00);
      end else begin
        exp_gnt(1'b0, 1'b0, 8'(8'h4F + i), 8'h00); exp_rd(1'b0, 8'(8'h5F + i));
        vec(1, 0, 0, 8'(8'h4F + i), 8'h00, 0, 0, 0, 8'h00, 8'h00);
      end
    end
    idle();
    idle();
    done = 1'b1;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    while (gnt_q.size() > 0 && gnt_q[0][GW-1 -: 16] < 16'(cyc)) begin
      checks++; errors++;
      $display("FAIL grant cyc=%0d got=none exp=%h", cyc, gnt_q.pop_front());
    end
    while (rd_q.size() > 0 && rd_q[0][RW-1 -: 16] < 16'(cyc)) begin
      checks++; errors++;
      $display("FAIL rvalid cyc=%0d got=none exp=%h", cyc, rd_q.pop_front());
    end
    while (st_q.size() > 0 && st_q[0][SW-1 -: 16] < 16'(cyc)) begin
      checks++; errors++;
      $display("FAIL state cyc=%0d got=none exp=%h", cyc, st_q.pop_front());
    end

    checks++;
    if (m0_if.gnt && m1_if.gnt) begin
      errors++;
      $display("FAIL gnt_onehot cyc=%0d got=both exp=at_most_one", cyc);
    end else if (m0_if.gnt || m1_if.gnt) begin
      g_obs = {16'(cyc), m1_if.gnt, mem_re, mem_we, mem_addr, mem_wdata};
      if (gnt_q.size() == 0) begin
        errors++;
        $display("FAIL grant cyc=%0d got=%h exp=none", cyc, g_obs);
      end else begin
        g_exp = gnt_q.pop_front();
        if (g_obs !== g_exp) begin
          errors++;
          $display("FAIL grant cyc=%0d got=%h exp=%h", cyc, g_obs, g_exp);
        end
      end
    end else if (gnt_q.size() > 0 && gnt_q[0][GW-1 -: 16] == 16'(cyc)) begin
      errors++;
      $display("FAIL grant cyc=%0d got=none exp=%h", cyc, gnt_q.pop_front());
    end else if ({mem_re, mem_we, mem_addr, mem_wdata} !== 18'd0) begin
      errors++;
      $display("FAIL mem_idle cyc=%0d got=%h exp=0", cyc, {mem_re, mem_we, mem_addr, mem_wdata});
    end

    checks++;
    if (mem_re && mem_we) begin
      errors++;
      $display("FAIL re_we_excl cyc=%0d got=re1_we1 exp=exclusive", cyc);
    end

    checks++;
    if (m0_if.rvalid && m1_if.rvalid) begin
      errors++;
      $display("FAIL rvalid_onehot cyc=%0d got=both exp=at_most_one", cyc);
    end else if (m0_if.rvalid || m1_if.rvalid) begin
      r_obs = {16'(cyc), m1_if.rvalid, m1_if.rvalid ? m1_if.rdata : m0_if.rdata};
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid cyc=%0d got=%h exp=none", cyc, r_obs);
      end else begin
        r_exp = rd_q.pop_front();
        if (r_obs !== r_exp) begin
          errors++;
          $display("FAIL rvalid cyc=%0d got=%h exp=%h", cyc, r_obs, r_exp);
        end
      end
    end else if (rd_q.size() > 0 && rd_q[0][RW-1 -: 16] == 16'(cyc)) begin
      errors++;
      $display("FAIL rvalid cyc=%0d got=none exp=%h", cyc, rd_q.pop_front());
    end

    if (st_q.size() > 0 && st_q[0][SW-1 -: 16] == 16'(cyc)) begin
      checks++;
      s_exp = st_q.pop_front();
      s_obs = {16'(cyc), dbg_state, dbg_lock_cnt};
      if (s_obs !== s_exp) begin
        errors++;
        $display("FAIL state cyc=%0d got=%h exp=%h", cyc, s_obs, s_exp);
      end
    end

    if (done || cyc > 500) begin
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=running exp=done", cyc);
      end else if (gnt_q.size() + rd_q.size() + st_q.size() != 0) begin
        errors++;
        $display("FAIL leftover got=%0d exp=0", gnt_q.size() + rd_q.size() + st_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

endmodule
